// File: rtl/glip_channel_arbiter.sv
// glip_channel_arbiter: shares one GLIP FIFO link between CHANNELS on-chip clients.
// TX side: round-robin arbiter that frames each client burst with a header word.
// RX side: header-driven demux of host words to a single client, or drop on bad header.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   TX_IDLE  | no grant; round-robin search for the next requesting client
//   TX_HDR   | header {A, ch, len} offered on the link
//   TX_DATA  | granted client streams exactly len words to the link
//   RX_HDR   | consuming a host header word
//   RX_DATA  | forwarding cnt host words to the addressed client
//   RX_DROP  | discarding cnt host words after a bad channel number
module glip_channel_arbiter #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        fifo_out_valid,
    input  logic                        fifo_out_ready,
    output logic [WIDTH-1:0]            fifo_out_data,
    input  logic                        fifo_in_valid,
    output logic                        fifo_in_ready,
    input  logic [WIDTH-1:0]            fifo_in_data,
    input  logic [CHANNELS-1:0]         cl_tx_valid,
    output logic [CHANNELS-1:0]         cl_tx_ready,
    input  logic [CHANNELS*8-1:0]       cl_tx_len,
    input  logic [CHANNELS*WIDTH-1:0]   cl_tx_data,
    output logic [CHANNELS-1:0]         cl_rx_valid,
    input  logic [CHANNELS-1:0]         cl_rx_ready,
    output logic [WIDTH-1:0]            cl_rx_data,
    input  logic                        clear_error,
    output logic                        proto_error,
    output logic                        tx_busy
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BURST);
    localparam logic [CHW-1:0] RR_INIT = CHW'(CHANNELS - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA} tx_state_t;
    typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DROP} rx_state_t;

    tx_state_t      tx_state_q, tx_state_d;
    logic [CHW-1:0] tx_ch_q, tx_ch_d;
    logic [7:0]     tx_cnt_q, tx_cnt_d;
    logic [CHW-1:0] rr_q, rr_d;

    rx_state_t      rx_state_q, rx_state_d;
    logic [CHW-1:0] rx_ch_q, rx_ch_d;
    logic [7:0]     rx_cnt_q, rx_cnt_d;
    logic           proto_error_q, proto_error_d;

    logic           pick_found;
    logic [CHW-1:0] pick_ch;
    logic [7:0]     pick_len;
    logic           fifo_in_ready_c;

    // State registers for both FSMs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            tx_ch_q       <= '0;
            tx_cnt_q      <= '0;
            rr_q          <= RR_INIT;
            rx_state_q    <= RX_HDR;
            rx_ch_q       <= '0;
            rx_cnt_q      <= '0;
            proto_error_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_ch_q       <= tx_ch_d;
            tx_cnt_q      <= tx_cnt_d;
            rr_q          <= rr_d;
            rx_state_q    <= rx_state_d;
            rx_ch_q       <= rx_ch_d;
            rx_cnt_q      <= rx_cnt_d;
            proto_error_q <= proto_error_d;
        end
    end

    // Round-robin pick: first requesting client after rr, wrapping; burst length clamped.
    always_comb begin
        int idx;
        logic [7:0] raw_len;
        idx        = 0;
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(rr_q) + i) % CHANNELS;
            if (!pick_found && cl_tx_valid[idx]) begin
                pick_found = 1'b1;
                pick_ch    = CHW'(idx);
            end
        end
        raw_len  = cl_tx_len[pick_ch*8 +: 8];
        pick_len = (raw_len > MAX_LEN) ? MAX_LEN : raw_len;
    end

    // TX FSM: header then exactly len data words from the held grant.
    always_comb begin
        tx_state_d     = tx_state_q;
        tx_ch_d        = tx_ch_q;
        tx_cnt_d       = tx_cnt_q;
        rr_d           = rr_q;
        fifo_out_valid = 1'b0;
        fifo_out_data  = '0;
        cl_tx_ready    = '0;
        case (tx_state_q)
            TX_IDLE: begin
                if (pick_found) begin
                    if (pick_len == 8'd0) begin
                        // zero-length request: skip client so it cannot block the ring
                        rr_d = pick_ch;
                    end else begin
                        tx_ch_d    = pick_ch;
                        tx_cnt_d   = pick_len;
                        tx_state_d = TX_HDR;
                    end
                end
            end
            TX_HDR: begin
                fifo_out_valid = 1'b1;
                fifo_out_data  = WIDTH'({4'hA, 4'(tx_ch_q), tx_cnt_q});
                if (fifo_out_ready) begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                fifo_out_valid       = cl_tx_valid[tx_ch_q];
                fifo_out_data        = cl_tx_data[tx_ch_q*WIDTH +: WIDTH];
                cl_tx_ready[tx_ch_q] = fifo_out_ready;
                if (cl_tx_valid[tx_ch_q] && fifo_out_ready) begin
                    tx_cnt_d = tx_cnt_q - 8'd1;
                    if (tx_cnt_q == 8'd1) begin
                        rr_d       = tx_ch_q;
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX FSM: decode header, then forward or drop the announced word count.
    always_comb begin
        logic [15:0] hdr;
        logic        proto_set;
        hdr             = fifo_in_data[15:0];
        proto_set       = 1'b0;
        rx_state_d      = rx_state_q;
        rx_ch_d         = rx_ch_q;
        rx_cnt_d        = rx_cnt_q;
        fifo_in_ready_c = 1'b0;
        cl_rx_valid     = '0;
        cl_rx_data      = fifo_in_data;
        case (rx_state_q)
            RX_HDR: begin
                fifo_in_ready_c = 1'b1;
                if (fifo_in_valid) begin
                    if (hdr[15:12] != 4'h5) begin
                        proto_set = 1'b1;
                    end else if (int'(hdr[11:8]) >= CHANNELS) begin
                        proto_set = 1'b1;
                        rx_cnt_d  = hdr[7:0];
                        if (hdr[7:0] != 8'd0) begin
                            rx_state_d = RX_DROP;
                        end
                    end else if (hdr[7:0] != 8'd0) begin
                        rx_ch_d    = CHW'(hdr[11:8]);
                        rx_cnt_d   = hdr[7:0];
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                cl_rx_valid[rx_ch_q] = fifo_in_valid;
                fifo_in_ready_c      = cl_rx_ready[rx_ch_q];
                if (fifo_in_valid && cl_rx_ready[rx_ch_q]) begin
                    rx_cnt_d = rx_cnt_q - 8'd1;
                    if (rx_cnt_q == 8'd1) begin
                        rx_state_d = RX_HDR;
                    end
                end
            end
            RX_DROP: begin
                fifo_in_ready_c = 1'b1;
                if (fifo_in_valid) begin
                    rx_cnt_d = rx_cnt_q - 8'd1;
                    if (rx_cnt_q == 8'd1) begin
                        rx_state_d = RX_HDR;
                    end
                end
            end
            default: rx_state_d = RX_HDR;
        endcase
        // a new error wins over a simultaneous clear
        if (proto_set) begin
            proto_error_d = 1'b1;
        end else if (clear_error) begin
            proto_error_d = 1'b0;
        end else begin
            proto_error_d = proto_error_q;
        end
    end

    // RX_HDR would otherwise present ready while reset is held.
    assign fifo_in_ready = fifo_in_ready_c & ~rst;
    assign proto_error   = proto_error_q;
    assign tx_busy       = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_glip_channel_arbiter.sv
// Directed bench for glip_channel_arbiter: TX framing/arbitration, RX demux, errors, reset.
module tb_glip_channel_arbiter;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int MB = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_out_valid;
    logic              fifo_out_ready;
    logic [W-1:0]      fifo_out_data;
    logic              fifo_in_valid;
    logic              fifo_in_ready;
    logic [W-1:0]      fifo_in_data;
    logic [CH-1:0]     cl_tx_valid;
    logic [CH-1:0]     cl_tx_ready;
    logic [CH*8-1:0]   cl_tx_len;
    logic [CH*W-1:0]   cl_tx_data;
    logic [CH-1:0]     cl_rx_valid;
    logic [CH-1:0]     cl_rx_ready;
    logic [W-1:0]      cl_rx_data;
    logic              clear_error;
    logic              proto_error;
    logic              tx_busy;

    int errors = 0;
    int checks = 0;

    glip_channel_arbiter #(.WIDTH(W), .CHANNELS(CH), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ready (fifo_out_ready),
        .fifo_out_data  (fifo_out_data),
        .fifo_in_valid  (fifo_in_valid),
        .fifo_in_ready  (fifo_in_ready),
        .fifo_in_data   (fifo_in_data),
        .cl_tx_valid    (cl_tx_valid),
        .cl_tx_ready    (cl_tx_ready),
        .cl_tx_len      (cl_tx_len),
        .cl_tx_data     (cl_tx_data),
        .cl_rx_valid    (cl_rx_valid),
        .cl_rx_ready    (cl_rx_ready),
        .cl_rx_data     (cl_rx_data),
        .clear_error    (clear_error),
        .proto_error    (proto_error),
        .tx_busy        (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in TX_IDLE with the request already driven; ends in the idle cycle after the burst.
    task automatic tx_burst(input logic [15:0] hdr, input int n, input int ch, input logic [15:0] dbase);
        logic [15:0] word;
        step();
        chk("tx_hdr_valid", 32'(fifo_out_valid), 32'd1);
        chk("tx_hdr_data", 32'(fifo_out_data), 32'(hdr));
        chk("tx_hdr_busy", 32'(tx_busy), 32'd1);
        chk("tx_hdr_no_ready", 32'(cl_tx_ready), 32'd0);
        step();
        for (int i = 0; i < n; i++) begin
            word = dbase + 16'(i * 'h11);
            cl_tx_data[ch*W +: W] = word;
            #1;
            chk("tx_dat_valid", 32'(fifo_out_valid), 32'd1);
            chk("tx_dat_data", 32'(fifo_out_data), 32'(word));
            chk("tx_dat_ready", 32'(cl_tx_ready), 32'(1 << ch));
            step();
        end
        chk("tx_end_busy", 32'(tx_busy), 32'd0);
        chk("tx_end_valid", 32'(fifo_out_valid), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        fifo_out_ready = 1'b0;
        fifo_in_valid  = 1'b0;
        fifo_in_data   = '0;
        cl_tx_valid    = '0;
        cl_tx_len      = '0;
        cl_tx_data     = '0;
        cl_rx_ready    = '0;
        clear_error    = 1'b0;
        #12;
        chk("rst_out_valid", 32'(fifo_out_valid), 32'd0);
        chk("rst_in_ready", 32'(fifo_in_ready), 32'd0);
        chk("rst_tx_ready", 32'(cl_tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(cl_rx_valid), 32'd0);
        chk("rst_proto", 32'(proto_error), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(fifo_in_ready), 32'd1);

        // T1: single burst from client 1
        fifo_out_ready = 1'b1;
        cl_tx_valid = 4'b0010;
        cl_tx_len[1*8 +: 8] = 8'd3;
        tx_burst(16'hA103, 3, 1, 16'h0011);
        cl_tx_valid = '0;
        step();
        chk("t1_stays_idle", 32'(tx_busy), 32'd0);

        // T2: clients 0 and 2 compete; rr=1 so ch2 goes first
        cl_tx_valid = 4'b0101;
        cl_tx_len[0*8 +: 8] = 8'd2;
        cl_tx_len[2*8 +: 8] = 8'd2;
        tx_burst(16'hA202, 2, 2, 16'h2000);
        tx_burst(16'hA002, 2, 0, 16'h0A00);
        tx_burst(16'hA202, 2, 2, 16'h2100);
        cl_tx_valid = '0;
        step();

        // T3: oversize request clamped to MAX_BURST
        cl_tx_valid = 4'b1000;
        cl_tx_len[3*8 +: 8] = 8'd200;
        tx_burst(16'hA340, 64, 3, 16'h0100);

        // T6: re-arbitrated burst stalled by the link, then reset mid-burst
        step();
        chk("t6_hdr", 32'(fifo_out_data), 32'h0000A340);
        step();
        cl_tx_data[3*W +: W] = 16'h7777;
        step();
        step();
        fifo_out_ready = 1'b0;
        #1;
        chk("t6_stall_valid", 32'(fifo_out_valid), 32'd1);
        chk("t6_stall_ready", 32'(cl_tx_ready), 32'd0);
        step();
        chk("t6_stall_busy", 32'(tx_busy), 32'd1);
        chk("t6_stall_data", 32'(fifo_out_data), 32'h00007777);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(fifo_out_valid), 32'd0);
        chk("t6_rst_data", 32'(fifo_out_data), 32'd0);
        chk("t6_rst_tx_ready", 32'(cl_tx_ready), 32'd0);
        chk("t6_rst_busy", 32'(tx_busy), 32'd0);
        chk("t6_rst_in_ready", 32'(fifo_in_ready), 32'd0);
        fifo_out_ready = 1'b1;
        cl_tx_valid = 4'b0010;
        cl_tx_len[1*8 +: 8] = 8'd1;
        #1;
        rst = 1'b0;
        tx_burst(16'hA101, 1, 1, 16'h0055);
        cl_tx_valid = '0;

        // T4: host frame to client 2 with backpressure
        fifo_in_valid = 1'b1;
        fifo_in_data  = 16'h5202;
        cl_rx_ready   = 4'b0100;
        #1;
        chk("t4_hdr_ready", 32'(fifo_in_ready), 32'd1);
        chk("t4_hdr_rx_valid", 32'(cl_rx_valid), 32'd0);
        step();
        fifo_in_data = 16'hBEEF;
        #1;
        chk("t4_w0_valid", 32'(cl_rx_valid), 32'b0100);
        chk("t4_w0_data", 32'(cl_rx_data), 32'h0000BEEF);
        chk("t4_w0_ready", 32'(fifo_in_ready), 32'd1);
        cl_rx_ready = 4'b0000;
        #1;
        chk("t4_bp_ready", 32'(fifo_in_ready), 32'd0);
        step();
        chk("t4_bp_hold", 32'(cl_rx_valid), 32'b0100);
        cl_rx_ready = 4'b0100;
        step();
        fifo_in_data = 16'hCAFE;
        #1;
        chk("t4_w1_valid", 32'(cl_rx_valid), 32'b0100);
        chk("t4_w1_data", 32'(cl_rx_data), 32'h0000CAFE);
        step();
        fifo_in_valid = 1'b0;
        #1;
        chk("t4_back_hdr", 32'(fifo_in_ready), 32'd1);
        chk("t4_back_valid", 32'(cl_rx_valid), 32'd0);
        chk("t4_no_err", 32'(proto_error), 32'd0);

        // T5: bad magic, bad channel with drop, zero-length header, error clear
        fifo_in_valid = 1'b1;
        fifo_in_data  = 16'h1234;
        step();
        chk("t5_err_magic", 32'(proto_error), 32'd1);
        chk("t5_still_hdr", 32'(fifo_in_ready), 32'd1);
        fifo_in_data = 16'h5902;
        step();
        fifo_in_data = 16'h5101;
        #1;
        chk("t5_drop_ready", 32'(fifo_in_ready), 32'd1);
        chk("t5_drop_no_valid", 32'(cl_rx_valid), 32'd0);
        step();
        fifo_in_data = 16'h5001;
        #1;
        chk("t5_drop2_no_valid", 32'(cl_rx_valid), 32'd0);
        step();
        fifo_in_data = 16'h5100;
        step();
        fifo_in_valid = 1'b0;
        #1;
        chk("t5_zero_len_hdr", 32'(cl_rx_valid), 32'd0);
        chk("t5_zero_len_ready", 32'(fifo_in_ready), 32'd1);
        chk("t5_err_sticky", 32'(proto_error), 32'd1);
        clear_error   = 1'b1;
        fifo_in_valid = 1'b1;
        fifo_in_data  = 16'h7000;
        step();
        fifo_in_valid = 1'b0;
        #1;
        chk("t5_set_beats_clear", 32'(proto_error), 32'd1);
        step();
        chk("t5_cleared", 32'(proto_error), 32'd0);
        clear_error = 1'b0;
        step();
        chk("t5_stays_clear", 32'(proto_error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
